// File: rtl/rr_arbiter_onehot.sv
// rr_arbiter_onehot
//   Round-robin arbiter with a registered one-hot grant. The grant drives a
//   one-hot mux with a default input, so an all-zero grant means "route the
//   default". A rotating priority pointer gives the requester just after the
//   last winner the highest priority on the next arbitration.
//
//   Optional feature macro: RR_ARB_LOCK_EN
//     defined   : lock=1 holds the current grant and pointer for as long as
//                 the granted requester keeps its request raised.
//     undefined : the lock input is accepted but has no effect.
module rr_arbiter_onehot #(
    parameter  int N    = 8,
    localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic            lock,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx
);

    // Registered state: grant vector, its encoded index, and the priority pointer.
    logic [N-1:0]    gnt_q, gnt_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;

    // Result of the circular scan.
    logic            found;
    logic [IDXW-1:0] win;
    logic [IDXW-1:0] ptr_after_win;
    logic            hold;

    // Circular scan of req starting at ptr_q; the first set bit wins.
    always_comb begin
        int              cand;
        logic [IDXW-1:0] cand_idx;
        found    = 1'b0;
        win      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand     = (int'(ptr_q) + i) % N;
            cand_idx = IDXW'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                win   = cand_idx;
            end
        end
    end

    // Pointer moves to the requester just past the winner, wrapping N-1 -> 0.
    always_comb begin
        if (win == IDXW'(N - 1)) begin
            ptr_after_win = '0;
        end else begin
            ptr_after_win = win + IDXW'(1);
        end
    end

`ifdef RR_ARB_LOCK_EN
    // Burst ownership: keep the grant while the locked owner still requests.
    always_comb begin
        hold = lock && gnt_valid_q && req[gnt_idx_q];
    end
`else
    // Lock has no effect in this build; the input is kept for port compatibility.
    logic unused_lock;
    assign unused_lock = lock;

    // No hold logic without the lock feature.
    always_comb begin
        hold = 1'b0;
    end
`endif

    // Next-state selection: freeze when disabled or locked, else arbitrate.
    always_comb begin
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        ptr_d       = ptr_q;
        if (en && !hold) begin
            if (found) begin
                gnt_d       = '0;
                gnt_d[win]  = 1'b1;
                gnt_valid_d = 1'b1;
                gnt_idx_d   = win;
                ptr_d       = ptr_after_win;
            end else begin
                // Nothing pending: route the mux default, keep the pointer.
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_idx_d   = '0;
            end
        end
    end

    // State registers; reset clears the grant and returns priority to requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            ptr_q       <= '0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            ptr_q       <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// tb_rr_arbiter_onehot
//   Scoreboard bench: the stimulus process pushes the expected grant for each
//   cycle into a queue; a monitor pops and compares one entry after every
//   rising edge. Directed sequences use literal expected grants, the random
//   phase uses a distance-based reference model. Honours RR_ARB_LOCK_EN.
module tb_rr_arbiter_onehot;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       lock = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_idx;

    rr_arbiter_onehot #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .lock      (lock),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic [7:0] req;
        logic       en;
        logic       held;
        logic       rst;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   started = 1'b0;
    bit   done = 1'b0;

    // Reference model: priority pointer and last winner (-1 = no grant).
    int   m_ptr = 0;
    int   m_win = -1;
    int   wait_cnt[N];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Winner = requester with the smallest circular distance from the pointer.
    function automatic int pick(input logic [7:0] r, input int p);
        int best = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (r[i] && ((i - p + N) % N) < bestd) begin
                bestd = (i - p + N) % N;
                best  = i;
            end
        end
        return best;
    endfunction

    function automatic int hex2idx(input int h);
        int r = -1;
        for (int i = 0; i < N; i++) if (h == (1 << i)) r = i;
        return r;
    endfunction

    task automatic model_step(input logic [7:0] r, input logic e, input logic l, output logic held);
        int w;
        held = 1'b0;
        if (!e) return;
`ifdef RR_ARB_LOCK_EN
        if (l && m_win >= 0 && r[m_win]) begin
            held = 1'b1;
            return;
        end
`endif
        w = pick(r, m_ptr);
        if (w >= 0) begin
            m_win = w;
            m_ptr = (w + 1) % N;
        end else begin
            m_win = -1;
        end
    endtask

    task automatic push_exp(input int w, input logic [7:0] r, input logic e,
                            input logic held, input logic rs);
        exp_t x;
        x.gnt   = 8'h00;
        if (w >= 0) x.gnt[w] = 1'b1;
        x.idx   = (w >= 0) ? 3'(w) : 3'd0;
        x.valid = (w >= 0);
        x.req   = r;
        x.en    = e;
        x.held  = held;
        x.rst   = rs;
        sb_q.push_back(x);
        started = 1'b1;
    endtask

    // One arbitration cycle; exp_hex < 0 takes the expectation from the model.
    task automatic drive(input logic [7:0] r, input logic e, input logic l, input int exp_hex);
        logic held;
        @(negedge clk);
        rst_n = 1'b1;
        req   = r;
        en    = e;
        lock  = l;
        model_step(r, e, l, held);
        push_exp((exp_hex < 0) ? m_win : hex2idx(exp_hex), r, e, held, 1'b0);
    endtask

    task automatic rst_cycle();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'h00;
        en    = 1'b0;
        lock  = 1'b0;
        m_ptr = 0;
        m_win = -1;
        push_exp(-1, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: one scoreboard entry per rising edge, plus invariants and starvation.
    initial begin
        exp_t x;
        int   maxw;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                $display("[TB] t=%0t rst_n=%0b en=%0b req=%02h gnt=%02h idx=%0d valid=%0b",
                         $time, !x.rst, x.en, x.req, gnt, gnt_idx, gnt_valid);
                check("gnt", 32'(gnt), 32'(x.gnt));
                check("gnt_valid", 32'(gnt_valid), 32'(x.valid));
                check("gnt_idx", 32'(gnt_idx), 32'(x.idx));
                check("onehot0", 32'($onehot0(gnt)), 32'd1);
                check("valid_vs_or", 32'(gnt_valid), 32'(|gnt));
                check("gnt_vs_shift", 32'(gnt), 32'(8'(gnt_valid) << gnt_idx));
                maxw = 0;
                for (int i = 0; i < N; i++) begin
                    if (x.rst || x.held || !x.req[i]) wait_cnt[i] = 0;
                    else if (x.en) wait_cnt[i] = gnt[i] ? 0 : wait_cnt[i] + 1;
                    if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
                end
                check("starvation_bound", 32'(maxw < N), 32'd1);
            end else if (started && !done) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cur_req;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;

        // Reset state.
        repeat (3) rst_cycle();

        // Sparse: 0x21 alternates 01/20; idle clears; pointer survives idle.
        drive(8'h21, 1'b1, 1'b0, 8'h01);
        drive(8'h21, 1'b1, 1'b0, 8'h20);
        drive(8'h21, 1'b1, 1'b0, 8'h01);
        drive(8'h21, 1'b1, 1'b0, 8'h20);
        drive(8'h00, 1'b1, 1'b0, 8'h00);
        drive(8'h21, 1'b1, 1'b0, 8'h01);

        // Async reset while 0x10 is granted: outputs clear without a clock edge.
        drive(8'h10, 1'b1, 1'b0, 8'h10);
        @(negedge clk);
        check("pre_reset_gnt", 32'(gnt), 32'h10);
        rst_n = 1'b0;
        m_ptr = 0;
        m_win = -1;
        push_exp(-1, 8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        check("async_rst_gnt", 32'(gnt), 32'h00);
        check("async_rst_valid", 32'(gnt_valid), 32'h0);
        check("async_rst_idx", 32'(gnt_idx), 32'h0);

        // Rotation after release: 01,02,...,80,01.
        for (int i = 0; i < 9; i++) drive(8'hFF, 1'b1, 1'b0, 1 << (i % 8));

        // Freeze: grant 04, en=0 for 5 cycles with changing req, then 08.
        drive(8'h04, 1'b1, 1'b0, 8'h04);
        for (int i = 0; i < 5; i++) drive(8'($urandom), 1'b0, 1'($urandom), 8'h04);
        drive(8'hFF, 1'b1, 1'b0, 8'h08);

        // Lock: owner 0 holds while requesting (feature build); then 1 takes over.
        drive(8'h03, 1'b1, 1'b0, 8'h01);
        for (int i = 0; i < 4; i++) begin
`ifdef RR_ARB_LOCK_EN
            drive(8'h03, 1'b1, 1'b1, 8'h01);
`else
            drive(8'h03, 1'b1, 1'b1, (i % 2 == 0) ? 8'h02 : 8'h01);
`endif
        end
        drive(8'h02, 1'b1, 1'b1, 8'h02);

        // Random phase against the reference model.
        cur_req = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 999) == 0) begin
                rst_cycle();
            end else begin
                if ($urandom_range(0, 9) >= 7) begin
                    cur_req = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) cur_req = cur_req & 8'($urandom);
                end
                drive(cur_req, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0), -1);
            end
        end

        @(posedge clk);
        #3;
        done = 1'b1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
